// File: rtl/fnd_count_scheduler_if.sv
// fnd_count_scheduler_if: run/clear/direction controls in, packed-BCD count, tick/wrap pulses and digit scan out
interface fnd_count_scheduler_if;
    logic        i_run;
    logic        i_clear;
    logic        i_up_down;
    logic [15:0] o_count;
    logic        o_running;
    logic        o_count_tick;
    logic        o_wrap;
    logic [3:0]  o_digit_sel;
    logic [3:0]  o_bcd;
    modport master (
        output i_run, i_clear, i_up_down,
        input  o_count, o_running, o_count_tick, o_wrap, o_digit_sel, o_bcd
    );
    modport slave (
        input  i_run, i_clear, i_up_down,
        output o_count, o_running, o_count_tick, o_wrap, o_digit_sel, o_bcd
    );
endinterface

// File: rtl/fnd_count_scheduler.sv
// fnd_count_scheduler: IDLE/RUN/PAUSE sequencer for a 4-digit BCD up/down counter with count and scan enables; ports i_clk, i_reset, bus (slave)
module fnd_count_scheduler #(
    parameter int COUNT_DIV = 10_000_000,
    parameter int SCAN_DIV  = 100_000
) (
    input logic                 i_clk,
    input logic                 i_reset,
    fnd_count_scheduler_if.slave bus
);
    localparam int CW = $clog2(COUNT_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cpre_q, cpre_d;
    logic [SW-1:0] spre_q, spre_d;
    logic [15:0]   count_q, count_d, count_nx;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    sel_q, sel_d, nib;
    logic          tick_q, tick_d, wrap_q, wrap_d, run_q, run_d, cy, wrap_nx, c_last, s_last;
    always_comb begin
        count_nx = count_q;
        cy = 1'b1;
        nib = '0;
        for (int i = 0; i < 4; i++) begin
            nib = count_q[4*i +: 4];
            count_nx[4*i +: 4] = !cy ? nib :
                                 bus.i_up_down ? (nib == 4'd9 ? 4'd0 : nib + 4'd1) :
                                                 (nib == 4'd0 ? 4'd9 : nib - 4'd1);
            cy = cy & (bus.i_up_down ? nib == 4'd9 : nib == 4'd0);
        end
        wrap_nx = cy;
    end
    always_comb begin
        state_d = state_q;
        cpre_d  = cpre_q;
        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        c_last  = cpre_q == CW'(COUNT_DIV - 1);
        if (bus.i_clear) begin
            state_d = IDLE;
            cpre_d  = '0;
            count_d = '0;
        end else if (bus.i_run) begin
            state_d = state_q == RUN ? PAUSE : RUN;
            cpre_d  = state_q == IDLE ? '0 : cpre_q;
        end else if (state_q == RUN) begin
            cpre_d  = c_last ? '0 : cpre_q + CW'(1);
            count_d = c_last ? count_nx : count_q;
            tick_d  = c_last;
            wrap_d  = c_last & wrap_nx;
        end
        run_d  = state_d == RUN;
        s_last = spre_q == SW'(SCAN_DIV - 1);
        spre_d = s_last ? '0 : spre_q + SW'(1);
        idx_d  = idx_q + {1'b0, s_last};
        sel_d  = ~(4'b0001 << idx_d);
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cpre_q  <= '0;
            spre_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            sel_q   <= 4'b1110;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cpre_q  <= cpre_d;
            spre_q  <= spre_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            run_q   <= run_d;
        end
    end
    assign bus.o_count      = count_q;
    assign bus.o_running    = run_q;
    assign bus.o_count_tick = tick_q;
    assign bus.o_wrap       = wrap_q;
    assign bus.o_digit_sel  = sel_q;
    assign bus.o_bcd        = count_q[{idx_q, 2'b00} +: 4];
endmodule
